// File: rtl/mb_frame_serializer_if.sv
// Request/serial-output bundle for mb_frame_serializer.
// The master drives the frame request; the slave (serializer) drives the serial stream and status.
interface mb_frame_serializer_if;
   logic       start;
   logic [7:0] dataIn;
   logic [3:0] addr;
   logic       serIn;
   logic [3:0] PB;
   logic [1:0] LB;
   logic       busy;
   logic       done;

   modport master (
      output start, dataIn, addr,
      input  serIn, PB, LB, busy, done
   );

   modport slave (
      input  start, dataIn, addr,
      output serIn, PB, LB, busy, done
   );
endinterface

// File: rtl/mb_frame_serializer.sv
// Frame serializer: start bit (1), 8 data bits LSB first, optional even-parity bit, stop bit (0).
// Define MB_PARITY_EN to insert the parity stage between DATA and STOP.
module mb_frame_serializer (
   input logic                  clk,
   input logic                  rst,
   mb_frame_serializer_if.slave bus
);

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StStrt = 3'd1,
      StData = 3'd2,
`ifdef MB_PARITY_EN
      StPar  = 3'd3,
`endif
      StStop = 3'd4
   } state_e;

   state_e     state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] data_q, data_d;
   logic       ser_q, ser_d;
   logic [3:0] pb_q, pb_d;
   logic [1:0] lb_q, lb_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic [2:0] nxt_idx;

   assign nxt_idx = bit_cnt_q + 3'd1;

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      data_d    = data_q;
      ser_d     = ser_q;
      pb_d      = pb_q;
      lb_d      = lb_q;
      busy_d    = busy_q;
      done_d    = 1'b0;

      case (state_q)
         StIdle: begin
            ser_d = 1'b0;
            if (bus.start) begin
               state_d = StStrt;
               data_d  = bus.dataIn;
               pb_d    = 4'b0001 << bus.addr[3:2];
               lb_d    = bus.addr[1:0];
               busy_d  = 1'b1;
               ser_d   = 1'b1;
            end
         end
         StStrt: begin
            state_d   = StData;
            bit_cnt_d = 3'd0;
            ser_d     = data_q[0];
         end
         StData: begin
            // Counter wraps 7->0 on the last bit, leaving it ready for the next frame.
            bit_cnt_d = nxt_idx;
            if (bit_cnt_q == 3'd7) begin
`ifdef MB_PARITY_EN
               state_d = StPar;
               ser_d   = ^data_q;
`else
               state_d = StStop;
               ser_d   = 1'b0;
`endif
            end else begin
               ser_d = data_q[nxt_idx];
            end
         end
`ifdef MB_PARITY_EN
         StPar: begin
            state_d = StStop;
            ser_d   = 1'b0;
         end
`endif
         StStop: begin
            state_d = StIdle;
            ser_d   = 1'b0;
            pb_d    = 4'b0000;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
         default: begin
            state_d = StIdle;
            ser_d   = 1'b0;
            pb_d    = 4'b0000;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         bit_cnt_q <= 3'd0;
         data_q    <= 8'h00;
         ser_q     <= 1'b0;
         pb_q      <= 4'b0000;
         lb_q      <= 2'b00;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         data_q    <= data_d;
         ser_q     <= ser_d;
         pb_q      <= pb_d;
         lb_q      <= lb_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.serIn = ser_q;
   assign bus.PB    = pb_q;
   assign bus.LB    = lb_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;

endmodule

// File: tb/tb_mb_frame_serializer.sv
// Self-checking bench for mb_frame_serializer; expected frames come from a bit-list model.
// Parity expectations follow MB_PARITY_EN in the same way as the design build.
module tb_mb_frame_serializer;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_err = 0;
   int   n_checks = 0;
   logic [15:0] last_bits;

   mb_frame_serializer_if bus ();

   mb_frame_serializer u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference frame: start 1, data LSB first, optional even parity, stop 0.
   task automatic build_frame(input logic [7:0] d, output bit q[$]);
      q = {};
      q.push_back(1'b1);
      for (int i = 0; i < 8; i++) q.push_back(d[i]);
`ifdef MB_PARITY_EN
      q.push_back(^d);
`endif
      q.push_back(1'b0);
   endtask

   task automatic check_idle(input string tag, input logic [1:0] lb_exp);
      chk({tag, ".ser"}, 32'(bus.serIn), 32'd0);
      chk({tag, ".pb"}, 32'(bus.PB), 32'd0);
      chk({tag, ".lb"}, 32'(bus.LB), 32'(lb_exp));
      chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
      chk({tag, ".done"}, 32'(bus.done), 32'd0);
   endtask

   // pre_started: request already accepted in the previous done cycle.
   // keep_start: hold start high through the frame, switching dataIn to mid_d mid-frame.
   task automatic send(input string tag, input logic [7:0] d, input logic [3:0] a,
                       input bit pre_started, input bit keep_start, input logic [7:0] mid_d);
      bit q[$];
      logic [3:0] pb_exp;
      build_frame(d, q);
      pb_exp = 4'b0001 << a[3:2];
      last_bits = '0;
      if (!pre_started) begin
         @(negedge clk);
         bus.start = 1'b1;
         bus.dataIn = d;
         bus.addr = a;
      end
      for (int k = 0; k < q.size(); k++) begin
         @(negedge clk);
         if (!keep_start) bus.start = 1'b0;
         if (keep_start && k == 4) bus.dataIn = mid_d;
         last_bits[k] = bus.serIn;
         chk($sformatf("%s.ser[%0d]", tag, k), 32'(bus.serIn), 32'(q[k]));
         chk($sformatf("%s.pb[%0d]", tag, k), 32'(bus.PB), 32'(pb_exp));
         chk($sformatf("%s.lb[%0d]", tag, k), 32'(bus.LB), 32'(a[1:0]));
         chk($sformatf("%s.busy[%0d]", tag, k), 32'(bus.busy), 32'd1);
         chk($sformatf("%s.done[%0d]", tag, k), 32'(bus.done), 32'd0);
      end
      @(negedge clk);
      chk({tag, ".done"}, 32'(bus.done), 32'd1);
      chk({tag, ".end_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, ".end_pb"}, 32'(bus.PB), 32'd0);
      chk({tag, ".end_ser"}, 32'(bus.serIn), 32'd0);
      chk({tag, ".end_lb"}, 32'(bus.LB), 32'(a[1:0]));
   endtask

   initial begin
      logic [7:0] d;
      logic [3:0] a;
      int gap;

      bus.start = 1'b0;
      bus.dataIn = 8'h00;
      bus.addr = 4'h0;
      #12;
      check_idle("reset", 2'b00);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_idle("post_reset", 2'b00);

      // Basic frame
      send("basic", 8'hA5, 4'b0110, 1'b0, 1'b0, 8'h00);
`ifndef MB_PARITY_EN
      chk("basic.pattern", 32'(last_bits[9:0]), 32'(10'b0101001011));
`endif
      @(negedge clk);
      check_idle("basic.idle", 2'b10);

      // Busy ignore and back-to-back acceptance in the done cycle
      send("busy_a5", 8'hA5, 4'b0110, 1'b0, 1'b1, 8'hFF);
      send("b2b_ff", 8'hFF, 4'b0110, 1'b1, 1'b0, 8'h00);
      @(negedge clk);
      check_idle("b2b.idle", 2'b10);

`ifdef MB_PARITY_EN
      send("parity", 8'h07, 4'b1111, 1'b0, 1'b0, 8'h00);
      chk("parity.bit", 32'(last_bits[9]), 32'd1);
      @(negedge clk);
      check_idle("parity.idle", 2'b11);
`endif

      // Reset during the 4th data bit
      @(negedge clk);
      bus.start = 1'b1;
      bus.dataIn = 8'h3C;
      bus.addr = 4'b1001;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      chk("rst_mid.busy_before", 32'(bus.busy), 32'd1);
      rst = 1'b0;
      #1;
      check_idle("rst_mid.now", 2'b00);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check_idle("rst_mid.held", 2'b00);
      end
      rst = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         check_idle("rst_mid.no_done", 2'b00);
      end
      send("after_rst", 8'h5A, 4'b0011, 1'b0, 1'b0, 8'h00);

      // Address sweep with random payloads and random idle gaps
      for (int i = 0; i < 16; i++) begin
         d = 8'($urandom);
         a = 4'(i);
         send($sformatf("sweep%0d", i), d, a, 1'b0, 1'b0, 8'h00);
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            check_idle($sformatf("sweep%0d.gap", i), a[1:0]);
         end
      end

      // Random frames, some back-to-back
      for (int i = 0; i < 8; i++) begin
         d = 8'($urandom);
         a = 4'($urandom);
         send($sformatf("rand%0d", i), d, a, 1'b0, 1'b0, 8'h00);
      end

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/mb_frame_serializer.md
MB_FRAME_SERIALIZER -- requirements
Module: mb_frame_serializer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, named as below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-low reset; 0 forces reset state immediately.
REQ-004 start  input  1  request to send one frame; sampled on rising clk.
REQ-005 dataIn  input  8  payload byte, captured when a request is accepted.
REQ-006 addr  input  4  destination; addr[3:2] selects the port group, addr[1:0] selects the line.
REQ-007 serIn  output  1  serial bit stream for the downstream multibroadcasting stage.
REQ-008 PB  output  4  one-hot port-group select; 4'b0000 when idle.
REQ-009 LB  output  2  line select; held stable for the whole frame.
REQ-010 busy  output  1  high while a frame is in progress.
REQ-011 done  output  1  one-cycle pulse after the last frame bit.

Function
REQ-012 States SHALL be IDLE, STRT, DATA, PAR (only when MB_PARITY_EN is defined) and STOP.
REQ-013 A request SHALL be accepted at a rising edge where start=1 and state=IDLE; dataIn and addr SHALL be latched at that edge.
REQ-014 start=1 while busy=1 SHALL be ignored; no request is queued.
REQ-015 On acceptance, the next state SHALL be STRT; PB SHALL become one-hot of addr[3:2] (00->0001, 01->0010, 10->0100, 11->1000); LB SHALL become addr[1:0].
REQ-016 STRT SHALL last 1 cycle with serIn=1.
REQ-017 DATA SHALL last 8 cycles and drive the latched byte LSB first; a 3-bit counter SHALL index the bit and wrap 7->0 on exit.
REQ-018 STOP SHALL last 1 cycle with serIn=0.
REQ-019 At the edge ending STOP, state SHALL return to IDLE, busy SHALL go to 0, PB SHALL go to 0000, and done SHALL be 1 for exactly that following cycle.
REQ-020 busy SHALL be 1 in STRT, DATA, PAR and STOP and 0 in IDLE.
REQ-021 In IDLE, serIn SHALL be 0 and LB SHALL keep its last value.
REQ-022 A start sampled in the cycle where done=1 SHALL be accepted, giving back-to-back frames with exactly one idle cycle between them.
REQ-023 Frame length SHALL be 10 cycles from STRT to STOP inclusive, or 11 cycles when MB_PARITY_EN is defined.
REQ-024 PB and LB SHALL NOT change between STRT and STOP inclusive.

Reset
REQ-025 rst=0 SHALL asynchronously force: state=IDLE, serIn=0, PB=4'b0000, LB=2'b00, busy=0, done=0, bit counter=0, latched data=0.
REQ-026 A reset asserted mid-frame SHALL abort the frame with no done pulse; after release the block SHALL be IDLE.
REQ-027 Outputs SHALL be registered with no combinational path from the inputs to the outputs.

Configuration
REQ-028 The macro MB_PARITY_EN SHALL control the parity stage.
REQ-029 With MB_PARITY_EN defined, a 1-cycle PAR state SHALL follow DATA and drive the even-parity bit (XOR of the 8 data bits) on serIn.
REQ-030 Without MB_PARITY_EN, DATA SHALL go directly to STOP and no PAR state or logic SHALL exist.

Verification
REQ-031 Basic frame: reset, then start=1 with dataIn=8'hA5, addr=4'b0110 -> PB=0010, LB=10; serIn=1,1,0,1,0,0,1,0,1,0 over 10 cycles; done pulses once.
REQ-032 Busy ignore: start held high through the frame with dataIn changed to 8'hFF mid-frame -> frame still carries 8'hA5; second frame starts in the done cycle with 8'hFF.
REQ-033 Parity (MB_PARITY_EN defined): dataIn=8'h07, addr=4'b1111 -> PB=1000, LB=11; PAR bit=1; frame is 11 cycles.
REQ-034 Reset mid-DATA: rst=0 during the 4th data bit -> PB=0000, busy=0, serIn=0 immediately; no done pulse; the next start gives a clean frame.
REQ-035 Address sweep: all 16 addr values -> PB/LB decode matches REQ-015 and stays stable for every frame cycle.
